// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// The producer drives data/valid; the transmitter answers with ready.
interface uart_tx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser.
// Frames run back to back while the FIFO holds bytes.
module uart_tx #(
    parameter int PARITY       = 0,
    parameter int CLKS_PER_BIT = 9,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic     clk,
    input  logic     n_rst,
    uart_tx_if.slave bus,
    output logic     tx,
    output logic     busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [2:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    idx;
    logic [7:0]    sr;
    logic          par;

    logic have;
    logic push;
    logic pop;
    logic bit_end;

    assign have      = (count != '0);
    assign bus.ready = (count != FULL);
    assign push      = n_rst && bus.valid && bus.ready;
    assign bit_end   = (baud == BAUD_LAST);
    // Only the registered count is consulted, so a byte is never
    // pushed and popped on the same edge.
    assign pop       = n_rst && have &&
                       ((state == IDLE) || (state == STOP && bit_end));
    assign busy      = (state != IDLE) || have;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
            tx    <= 1'b1;
            baud  <= '0;
            idx   <= '0;
            sr    <= '0;
            par   <= 1'b0;
        end else if (state == IDLE) begin
            if (pop) begin
                state <= START;
                tx    <= 1'b0;
                baud  <= '0;
                idx   <= '0;
                sr    <= mem[rd_ptr];
                par   <= ^mem[rd_ptr];
            end
        end else begin
            baud <= bit_end ? '0 : baud + 1'b1;
            if (bit_end) begin
                unique case (state)
                    START: begin
                        state <= DATA;
                        tx    <= sr[0];
                    end
                    DATA: begin
                        if (idx != 3'd7) begin
                            sr  <= {1'b0, sr[7:1]};
                            idx <= idx + 1'b1;
                            tx  <= sr[1];
                        end else if (PARITY != 0) begin
                            state <= PAR;
                            tx    <= par;
                        end else begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end
                    end
                    PAR: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                    default: begin
                        if (pop) begin
                            state <= START;
                            tx    <= 1'b0;
                            idx   <= '0;
                            sr    <= mem[rd_ptr];
                            par   <= ^mem[rd_ptr];
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: one instance without parity, one with even parity.
// A bit-period sampling monitor checks every frame against a byte queue.
module tb_uart_tx;
    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } exp_t;

    typedef struct {
        bit         sel;
        logic [7:0] d;
        logic       p;
        int         len;
    } vec_t;

    logic clk;
    logic n_rst;
    logic tx0, busy0;
    logic tx1, busy1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int epoch = 0;
    int frames [2];
    exp_t q0 [$];
    exp_t q1 [$];

    uart_tx_if b0 ();
    uart_tx_if b1 ();

    uart_tx #(.PARITY(0), .CLKS_PER_BIT(9), .FIFO_DEPTH(4)) u0 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (b0),
        .tx    (tx0),
        .busy  (busy0)
    );

    uart_tx #(.PARITY(1), .CLKS_PER_BIT(9), .FIFO_DEPTH(4)) u1 (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (b1),
        .tx    (tx1),
        .busy  (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic txv(input bit sel);
        return sel ? tx1 : tx0;
    endfunction

    function automatic logic busyv(input bit sel);
        return sel ? busy1 : busy0;
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? b1.ready : b0.ready;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic drv(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            b1.valid = v;
            b1.data  = d;
        end else begin
            b0.valid = v;
            b0.data  = d;
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic push_byte(input bit sel, input logic [7:0] b,
                             input logic p, input bit hold,
                             output int acc);
        int n = 0;
        drv(sel, 1'b1, b);
        while (!rdy(sel) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            chk("push_timeout", 1, 0);
            drv(sel, 1'b0, 8'h00);
            acc = cyc;
            return;
        end
        @(posedge clk);
        if (sel) q1.push_back('{b, p});
        else     q0.push_back('{b, p});
        @(negedge clk);
        acc = cyc;
        if (!hold) drv(sel, 1'b0, 8'h00);
    endtask

    task automatic frame_len(input bit sel, output int len);
        int n = 0;
        int t0;
        while (txv(sel) !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        n  = 0;
        while (busyv(sel) !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        len = cyc - t0;
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        while (busyv(sel) !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", 32'(n < 3000), 1);
    endtask

    task automatic mon(input bit sel);
        logic [7:0] b;
        logic       st, p, sp;
        int         ep;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1 && txv(sel) === 1'b0) begin
                ep = epoch;
                p  = 1'b0;
                repeat (4) @(negedge clk);
                st = txv(sel);
                for (int i = 0; i < 8; i++) begin
                    repeat (9) @(negedge clk);
                    b[i] = txv(sel);
                end
                if (sel) begin
                    repeat (9) @(negedge clk);
                    p = txv(sel);
                end
                repeat (9) @(negedge clk);
                sp = txv(sel);
                if (ep == epoch) begin
                    frames[sel]++;
                    if ((sel ? q1.size() : q0.size()) == 0) begin
                        chk("extra_frame", {24'h0, b}, 32'hffff_ffff);
                    end else begin
                        e = sel ? q1.pop_front() : q0.pop_front();
                        chk(sel ? "p_start" : "n_start", st, 0);
                        chk(sel ? "p_data" : "n_data", b, e.d);
                        if (sel) chk("p_parity", p, e.p);
                        chk(sel ? "p_stop" : "n_stop", sp, 1);
                    end
                end
            end
        end
    endtask

    initial mon(1'b0);
    initial mon(1'b1);

    initial begin
        vec_t  tbl [4];
        int    acc [7];
        int    a, len, f0, lows;
        logic [7:0] v;
        logic  e;

        tbl[0] = '{1'b1, 8'h07, 1'b1, 99};
        tbl[1] = '{1'b1, 8'hA3, 1'b0, 99};
        tbl[2] = '{1'b0, 8'h3C, 1'b0, 90};
        tbl[3] = '{1'b1, 8'hFF, 1'b0, 99};
        frames[0] = 0;
        frames[1] = 0;

        n_rst = 1'b0;
        drv(0, 1'b0, 8'h00);
        drv(1, 1'b0, 8'h00);
        @(negedge clk);
        chk("rst_tx0", tx0, 1);
        chk("rst_ready0", b0.ready, 1);
        chk("rst_busy0", busy0, 0);
        chk("rst_tx1", tx1, 1);
        chk("rst_busy1", busy1, 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // single 0x55, cycle-exact
        v = 8'h55;
        push_byte(0, v, 1'b0, 1'b0, a);
        chk("busy_rise", busy0, 1);
        chk("tx_pre", tx0, 1);
        for (int k = 1; k <= 91; k++) begin
            @(negedge clk);
            if (k <= 9)       e = 1'b0;
            else if (k <= 81) e = v[(k - 10) / 9];
            else              e = 1'b1;
            chk($sformatf("tx55_k%0d", k), tx0, e);
            if (k == 90) chk("busy_stop", busy0, 1);
            if (k == 91) chk("busy_fall", busy0, 0);
        end
        chk("edge_count", cyc - a, 91);

        for (int i = 0; i < 4; i++) begin
            push_byte(tbl[i].sel, tbl[i].d, tbl[i].p, 1'b0, a);
            frame_len(tbl[i].sel, len);
            chk($sformatf("len_v%0d", i), len, tbl[i].len);
        end
        repeat (3) @(negedge clk);

        // back-to-back stream
        f0 = frames[0];
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    push_byte(0, 8'(i), 1'b0, 1'b1, acc[i]);
                    if (i == 5) chk("full_ready", b0.ready, 0);
                end
                drv(0, 1'b0, 8'h00);
            end
            frame_len(0, len);
        join
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("acc_%0d", i), acc[i] - acc[1], i - 1);
        end
        chk("acc_6", acc[6] - acc[1], 92);
        chk("stream_len", len, 540);
        repeat (3) @(negedge clk);
        chk("stream_frames", frames[0] - f0, 6);
        chk("stream_q", q0.size(), 0);

        // reset during DATA bit 3 with two bytes queued
        push_byte(0, 8'hA5, 1'b0, 1'b1, a);
        push_byte(0, 8'h5A, 1'b0, 1'b1, acc[0]);
        push_byte(0, 8'hC3, 1'b0, 1'b0, acc[0]);
        while (cyc < a + 40) @(negedge clk);
        f0 = frames[0];
        epoch++;
        q0.delete();
        q1.delete();
        n_rst = 1'b0;
        drv(0, 1'b1, 8'hFF);
        @(negedge clk);
        n_rst = 1'b1;
        drv(0, 1'b0, 8'h00);
        chk("mid_rst_tx", tx0, 1);
        chk("mid_rst_ready", b0.ready, 1);
        chk("mid_rst_busy", busy0, 0);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx0 !== 1'b1) lows++;
        end
        chk("post_rst_quiet", lows, 0);
        chk("post_rst_frames", frames[0] - f0, 0);

        // dropped valid pulses while full
        f0 = frames[0];
        for (int i = 1; i <= 5; i++) begin
            push_byte(0, 8'(i * 17), 1'b0, 1'b1, a);
        end
        drv(0, 1'b1, 8'hEE);
        repeat (3) begin
            chk("gate_ready", b0.ready, 0);
            @(negedge clk);
        end
        drv(0, 1'b0, 8'h00);
        push_byte(0, 8'h66, 1'b0, 1'b0, a);
        wait_idle(0);
        repeat (3) @(negedge clk);
        chk("gate_frames", frames[0] - f0, 6);
        chk("gate_q", q0.size(), 0);
        chk("final_q1", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit half of the board UART. It accepts bytes over a valid/ready handshake into a small FIFO and serialises each byte onto `tx` as an 8-bit frame: start bit, LSB-first data, optional even parity, one stop bit. It runs in the 1 MHz fabric clock domain at 9 clocks per bit, matching the receive side's sampling, and drives the board's `tx` pin directly.

## Interface

Parameters:
- `PARITY`, 0: 1 = append even-parity bit after data; 0 = no parity bit.
- `CLKS_PER_BIT`, 9: clocks per bit period; integer ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO entries; power of two ≥ 2.

Ports:
- `clk` in 1: single clock (1 MHz nominal).
- `n_rst` in 1: reset; synchronous, active-low.
- `data` in 8: byte to send.
- `valid` in 1: `data` is offered this cycle.
- `ready` out 1: FIFO can accept; transfer occurs on an edge where `valid && ready`.
- `tx` out 1: serial line, idle high; registered.
- `busy` out 1: FSM not in IDLE or FIFO non-empty.

## Operation

- The FIFO has registered read/write pointers and a count of width clog2(FIFO_DEPTH)+1.
  - `ready = (count != FIFO_DEPTH)`.
  - A push and a pop on the same edge leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE → START: on an edge where count ≠ 0. That edge pops the FIFO head into shift register `sr`, sets `tx = 0`, and clears the baud counter and bit index.
  - Baud counter runs 0..CLKS_PER_BIT-1. A bit ends on the edge where the counter equals CLKS_PER_BIT-1; the counter then wraps to 0.
  - START end → DATA; `tx = sr[0]`.
  - DATA end with bit index < 7: shift `sr` right, increment the index, `tx` = next bit.
  - DATA end with bit index = 7: go to PAR if PARITY=1 (`tx` = XOR of the 8 data bits), else go to STOP (`tx = 1`).
  - PAR end → STOP; `tx = 1`.
  - STOP end with count ≠ 0: pop and go directly to START (`tx = 0`), with no idle gap.
  - STOP end with count = 0: go to IDLE; `tx` stays 1.
- Frame length is (10 + PARITY) × CLKS_PER_BIT clocks. Each bit is held exactly CLKS_PER_BIT cycles.
- `data` is captured into the FIFO only on a handshake. `data` may change freely otherwise.
- `valid` and `data` are ignored while `n_rst` = 0.

## Timing

- Reset values after the first edge with `n_rst` = 0:
  - State IDLE; `tx` = 1; FIFO empty (`ready` = 1); `busy` = 0.
  - Counters 0; `sr` = 0.
- Reset mid-frame: `tx` returns to 1 on that edge and FIFO contents are discarded. No partial frame resumes after release.
- Latency, idle block: a byte accepted on edge N (empty FIFO) is popped on edge N+1, so `tx` falls at N+1. The FSM samples only the registered count, so a push cannot be popped on the same edge.
- Busy FIFO: a pop and a push on the same edge are both honoured.
- Full FIFO: `ready` = 0. It returns to 1 combinationally in the cycle after the pop edge.
- `busy` is registered-derived, rising the cycle after the accept edge. It falls on the edge that enters IDLE with an empty FIFO.
- Throughput: one byte per (10 + PARITY) × CLKS_PER_BIT clocks, sustained indefinitely.

## Test plan

- **Single byte, no parity.** PARITY=0, single 0x55 accepted at edge N.
  - `tx` low for cycles N+1..N+9, then 1,0,1,0,1,0,1,0 with 9 cycles each, then high for 9 cycles.
  - IDLE at N+91; `busy` = 0 from N+91.
- **Parity set.** PARITY=1, byte 0x07: data bits 1,1,1,0,0,0,0,0, then parity bit 1 for 9 cycles, then stop. Total 99 cycles from `tx` fall to IDLE.
- **Parity clear.** PARITY=1, byte 0xA3: parity bit 0.
- **Back-to-back stream.** `valid` held high with bytes 0x01..0x06, depth 4.
  - Bytes 0x01..0x05 are accepted on consecutive edges; `ready` then drops.
  - 0x06 is accepted the cycle after frame 2 begins.
  - Every stop bit is immediately followed by a start bit; six frames total, 540 cycles.
- **Reset mid-frame.** Reset held for 1 cycle during DATA bit 3, with 2 bytes queued.
  - `tx` = 1, `ready` = 1, `busy` = 0 after the reset edge.
  - No further frames are sent.
- **Handshake gating.** `valid` pulses while `ready` = 0 (FIFO full) are dropped. Verify the transmitted byte sequence equals the accepted sequence exactly, checked with a bit-period sampling scoreboard.
